// File: rtl/apa102_mmio.sv
// Memory-mapped APA102 strip driver: a CPU-writable pixel buffer plus a control word
// that launches one start/pixel/end frame on a two-wire clock/data output.
module apa102_mmio #(
    parameter int          NUM_LEDS = 64,
    parameter int          CLK_DIV  = 4,
    parameter logic [19:0] BASE     = 20'h00001
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        wren,
    input  logic [31:0] address_dmem,
    input  logic [31:0] data,
    output logic [31:0] q_mmio,
    output logic        sel,
    output logic        led_clk,
    output logic        led_data,
    output logic        busy
);
    localparam int          IDXW       = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam int          DIVW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [11:0] CTRL_OFF   = 12'h100;
    localparam logic [11:0] STATUS_OFF = 12'h101;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_PIXEL,
        S_END
    } state_t;

    state_t           r_state;
    state_t           w_stateNext;
    logic [31:0]      r_mem [NUM_LEDS];
    logic [31:0]      r_fetch;
    logic [31:0]      r_shift;
    logic [31:0]      r_q;
    logic [IDXW-1:0]  r_idx;
    logic [DIVW-1:0]  r_div;
    logic [4:0]       r_bit;
    logic             r_ledClk;

    logic [11:0]      w_offset;
    logic             w_sel;
    logic             w_pixHit;
    logic             w_pixWr;
    logic             w_ctrlWr;
    logic             w_tick;
    logic             w_bitEnd;
    logic             w_wordEnd;
    logic             w_lastPix;
    logic [IDXW-1:0]  w_fetchIdx;
    logic             w_load;
    logic [31:0]      w_loadWord;

    assign w_offset   = address_dmem[11:0];
    assign w_sel      = (address_dmem[31:12] == BASE);
    assign w_pixHit   = (w_offset < 12'(NUM_LEDS));
    assign w_pixWr    = wren && w_sel && w_pixHit;
    assign w_ctrlWr   = wren && w_sel && (w_offset == CTRL_OFF);
    assign w_tick     = (r_div == DIVW'(CLK_DIV - 1));
    assign w_bitEnd   = (r_state != S_IDLE) && r_ledClk && w_tick;
    assign w_wordEnd  = w_bitEnd && (r_bit == 5'd31);
    assign w_lastPix  = (r_idx == IDXW'(NUM_LEDS - 1));

    // The buffer is read one word ahead so the next pixel is ready at the word boundary.
    assign w_fetchIdx = (r_state == S_PIXEL) ? r_idx + IDXW'(1) : '0;

    always_ff @(posedge clock) begin
        if (w_pixWr) begin
            r_mem[w_offset[IDXW-1:0]] <= data | 32'hE000_0000;
        end
        r_fetch <= r_mem[w_fetchIdx];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        w_load      = 1'b0;
        w_loadWord  = '0;
        case (r_state)
            S_IDLE: begin
                if (w_ctrlWr) begin
                    w_stateNext = S_START;
                    w_load      = 1'b1;
                end
            end
            S_START: begin
                if (w_wordEnd) begin
                    w_stateNext = S_PIXEL;
                    w_load      = 1'b1;
                    w_loadWord  = r_fetch;
                end
            end
            S_PIXEL: begin
                if (w_wordEnd) begin
                    w_load = 1'b1;
                    if (w_lastPix) begin
                        w_stateNext = S_END;
                        w_loadWord  = '1;
                    end else begin
                        w_loadWord  = r_fetch;
                    end
                end
            end
            S_END: begin
                if (w_wordEnd) begin
                    w_stateNext = S_IDLE;
                end
            end
            default: w_stateNext = S_IDLE;
        endcase
    end

    // After the end word the shifter is left alone, so led_data keeps its final 1.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_shift  <= '0;
            r_ledClk <= 1'b0;
            r_div    <= '0;
            r_bit    <= '0;
            r_idx    <= '0;
        end else begin
            if (r_state == S_IDLE) begin
                r_div    <= '0;
                r_ledClk <= 1'b0;
                r_bit    <= '0;
                r_idx    <= '0;
            end else begin
                r_div <= w_tick ? '0 : r_div + DIVW'(1);
                if (w_tick) begin
                    r_ledClk <= ~r_ledClk;
                end
                if (w_bitEnd) begin
                    r_bit <= r_bit + 5'd1;
                end
                if (w_wordEnd && (r_state == S_PIXEL)) begin
                    r_idx <= r_idx + IDXW'(1);
                end
            end
            if (w_load) begin
                r_shift <= w_loadWord;
            end else if (w_bitEnd && !w_wordEnd) begin
                r_shift <= {r_shift[30:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_q <= '0;
        end else if (!w_sel) begin
            r_q <= '0;
        end else if (w_pixHit) begin
            r_q <= r_mem[w_offset[IDXW-1:0]];
        end else if (w_offset == STATUS_OFF) begin
            r_q <= {31'b0, busy};
        end else begin
            r_q <= '0;
        end
    end

    assign busy     = (r_state != S_IDLE);
    assign sel      = w_sel;
    assign led_clk  = r_ledClk;
    assign led_data = r_shift[31];
    assign q_mmio   = r_q;

endmodule
